irq_ctrl: RTL and testbench

- Interrupt controller sitting directly upstream of MainPath; conditions and prioritises the external NMI and IRQ[7:0] lines before they reach the core.
- Edge-detects the lines, latches pending bits and applies the enable mask.
- Presents a single registered request carrying a cause code and a trap vector.
- Tracks the core's accept (ack) and return (done) handshake so that service is non-nested, except NMI, which preempts IRQ service one level deep.

---
 rtl/irq_pkg.sv | 24 ++
 rtl/irq_ctrl_if.sv | 21 ++
 rtl/irq_prio_enc.sv | 22 ++
 rtl/irq_ctrl.sv | 136 +++++++++++++
 tb/tb_irq_ctrl.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/irq_pkg.sv
// Shared constants for the interrupt controller: FSM state encoding, cause codes,
// default trap base and the cause-to-vector helper.
package irq_pkg;

    localparam logic [31:0] VEC_BASE_DEFAULT = 32'h0000_0100;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_REQ     = 3'd1;
    localparam logic [2:0] ST_SVC     = 3'd2;
    localparam logic [2:0] ST_NMI_REQ = 3'd3;
    localparam logic [2:0] ST_NMI_SVC = 3'd4;

    localparam logic [3:0] CAUSE_NMI = 4'd8;

    // Maskable causes 0-7 are the line index with the top bit clear.
    function automatic logic [3:0] irq_cause(input logic [2:0] idx);
        return {1'b0, idx};
    endfunction

    function automatic logic [31:0] trap_vec(input logic [31:0] base, input logic [3:0] cause);
        return base + {26'd0, cause, 2'b00};
    endfunction

endpackage

// File: rtl/irq_ctrl_if.sv
// Request/accept/return handshake between the interrupt controller (master)
// and the core (slave).
interface irq_ctrl_if;

    logic        int_req;
    logic [3:0]  int_cause;
    logic [31:0] int_vec;
    logic        int_ack;
    logic        int_done;

    modport master (
        output int_req, int_cause, int_vec,
        input  int_ack, int_done
    );

    modport slave (
        input  int_req, int_cause, int_vec,
        output int_ack, int_done
    );

endinterface

// File: rtl/irq_prio_enc.sv
// 8-bit masked priority encoder; the lowest set index wins.
module irq_prio_enc (
    input  logic [7:0] req,
    input  logic [7:0] mask,
    output logic       valid,
    output logic [2:0] idx
);

    logic [7:0] eligible;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        eligible = req & mask;
        valid    = |eligible;
        idx      = 3'd0;
        // Scan high-to-low so the lowest eligible index is the last one written.
        for (int i = 7; i >= 0; i--) begin
            if (eligible[i]) idx = 3'(i);
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: edge-detects NMI/IRQ, keeps pending bits, and presents one
// registered request with non-nested service except a one-deep NMI preemption.
// Optional build macro IRQ_CTRL_LEVEL_EN adds per-line level-sensitive selection.
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int          NUM_IRQ  = 8,
    parameter logic [31:0] VEC_BASE = VEC_BASE_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               NMI,
    input  logic [NUM_IRQ-1:0] IRQ,
    input  logic [NUM_IRQ-1:0] irq_mask,
    input  logic               glob_ie,
`ifdef IRQ_CTRL_LEVEL_EN
    input  logic [NUM_IRQ-1:0] irq_level_sel,
`endif
    irq_ctrl_if.master         core,
    output logic [NUM_IRQ-1:0] pending
);

    logic [NUM_IRQ-1:0] irq_q;
    logic               nmi_q;
    logic               nmi_pend;
    logic [2:0]         state;
    logic [2:0]         state_nx;
    logic [3:0]         svc_cause;
    logic               nmi_nested;

    logic [NUM_IRQ-1:0] irq_rise;
    logic               nmi_rise;
    logic               win_valid;
    logic [2:0]         win_idx;
    logic               irq_ack_edge;
    logic               nmi_ack_edge;
    logic [NUM_IRQ-1:0] irq_clr;
    logic [NUM_IRQ-1:0] edge_pend_nx;
    logic [NUM_IRQ-1:0] pending_nx;
    logic [3:0]         cause_nx;
    logic               enter_nmi;

    assign irq_rise = IRQ & ~irq_q;
    assign nmi_rise = NMI & ~nmi_q;

    // glob_ie gates only the maskable lines; NMI bypasses the encoder entirely.
    irq_prio_enc u_prio (
        .req   (pending),
        .mask  (irq_mask & {NUM_IRQ{glob_ie}}),
        .valid (win_valid),
        .idx   (win_idx)
    );

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (nmi_pend)       state_nx = ST_NMI_REQ;
                else if (win_valid) state_nx = ST_REQ;
            end
            ST_REQ: begin
                if (nmi_pend)           state_nx = ST_NMI_REQ;
                else if (core.int_ack)  state_nx = ST_REQ + 3'd1;
            end
            ST_SVC: begin
                // A return takes precedence so an NMI never resumes a finished IRQ.
                if (core.int_done)      state_nx = ST_IDLE;
                else if (nmi_pend)      state_nx = ST_NMI_REQ;
            end
            ST_NMI_REQ: begin
                if (core.int_ack)       state_nx = ST_NMI_SVC;
            end
            ST_NMI_SVC: begin
                if (core.int_done)      state_nx = nmi_nested ? ST_SVC : ST_IDLE;
            end
            default:                    state_nx = ST_IDLE;
        endcase
    end

    assign irq_ack_edge = (state == ST_REQ) && !nmi_pend && core.int_ack;
    assign nmi_ack_edge = (state == ST_NMI_REQ) && core.int_ack;
    assign enter_nmi    = (state != ST_NMI_REQ) && (state_nx == ST_NMI_REQ);

    assign irq_clr = irq_ack_edge ? ({{(NUM_IRQ-1){1'b0}}, 1'b1} << svc_cause[2:0])
                                  : '0;

    // A rising edge on the ack cycle wins over the clear of the same bit.
    assign edge_pend_nx = (pending & ~irq_clr) | irq_rise;

`ifdef IRQ_CTRL_LEVEL_EN
    assign pending_nx = (irq_level_sel & IRQ) | (~irq_level_sel & edge_pend_nx);
`else
    assign pending_nx = edge_pend_nx;
`endif

    always_comb begin
        cause_nx = core.int_cause;
        if (state == ST_IDLE && state_nx == ST_REQ)
            cause_nx = irq_cause(win_idx);
        else if (enter_nmi)
            cause_nx = CAUSE_NMI;
        else if (state == ST_NMI_SVC && state_nx == ST_SVC)
            cause_nx = svc_cause;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            irq_q          <= '0;
            nmi_q          <= 1'b0;
            nmi_pend       <= 1'b0;
            pending        <= '0;
            state          <= ST_IDLE;
            svc_cause      <= 4'd0;
            nmi_nested     <= 1'b0;
            core.int_req   <= 1'b0;
            core.int_cause <= 4'd0;
            core.int_vec   <= VEC_BASE;
        end else begin
            irq_q          <= IRQ;
            nmi_q          <= NMI;
            nmi_pend       <= (nmi_pend & ~nmi_ack_edge) | nmi_rise;
            pending        <= pending_nx;
            state          <= state_nx;
            core.int_req   <= (state_nx == ST_REQ) || (state_nx == ST_NMI_REQ);
            core.int_cause <= cause_nx;
            core.int_vec   <= trap_vec(VEC_BASE, cause_nx);
            if (state == ST_IDLE && state_nx == ST_REQ)
                svc_cause <= irq_cause(win_idx);
            // Only an NMI taken out of IRQ service has somewhere to return to.
            if (enter_nmi)
                nmi_nested <= (state == ST_SVC);
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed vector table, hand-written corner sequences, and
// randomized stimulus compared against a service-stack reference model.
module tb_irq_ctrl;
    import irq_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       NMI;
    logic [7:0] IRQ;
    logic [7:0] irq_mask;
    logic       glob_ie;
    logic [7:0] pending;

    int checks = 0;
    int errors = 0;

    irq_ctrl_if bus ();

    irq_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .NMI           (NMI),
        .IRQ           (IRQ),
        .irq_mask      (irq_mask),
        .glob_ie       (glob_ie),
`ifdef IRQ_CTRL_LEVEL_EN
        .irq_level_sel (8'h00),
`endif
        .core          (bus),
        .pending       (pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        nmi;
        logic [7:0]  irq;
        logic [7:0]  mask;
        logic        gie;
        logic        ack;
        logic        done;
        logic        req;
        logic [3:0]  cause;
        logic [31:0] vec;
        logic [7:0]  pend;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input logic req, input logic [3:0] cause,
                              input logic [31:0] vec, input logic [7:0] pend);
        check({tag, ".req"},   32'(bus.int_req),   32'(req));
        check({tag, ".cause"}, 32'(bus.int_cause), 32'(cause));
        check({tag, ".vec"},   bus.int_vec,        vec);
        check({tag, ".pend"},  32'(pending),       32'(pend));
    endtask

    task automatic drive(input logic r, input logic n, input logic [7:0] i, input logic [7:0] m,
                         input logic g, input logic a, input logic d);
        rst = r; NMI = n; IRQ = i; irq_mask = m; glob_ie = g;
        bus.int_ack = a; bus.int_done = d;
    endtask

    // One clock with the given inputs, then compare the registered outputs.
    task automatic step(input string tag, input logic n, input logic [7:0] i, input logic g,
                        input logic a, input logic d, input logic req, input logic [3:0] cause,
                        input logic [7:0] pend);
        drive(1'b0, n, i, 8'hFF, g, a, d);
        @(posedge clk); #1;
        check_outs(tag, req, cause, 32'h100 + 32'(cause) * 4, pend);
    endtask

    // Reference model: a presented request plus a stack of causes in service.
    int         m_pres;
    int         m_stack[$];
    logic [7:0] m_pend;
    bit         m_nmi;
    int         m_cause;
    logic [7:0] m_prev_irq;
    logic       m_prev_nmi;

    task automatic model_step();
        logic [7:0] rise, clr, elig;
        bit nrise, nclr;
        if (rst) begin
            m_pres = -1; m_stack.delete(); m_pend = 0; m_nmi = 0;
            m_cause = 0; m_prev_irq = 0; m_prev_nmi = 0;
            return;
        end
        rise  = IRQ & ~m_prev_irq;
        nrise = NMI && !m_prev_nmi;
        clr   = 0;
        nclr  = 0;
        elig  = glob_ie ? (m_pend & irq_mask) : 8'h00;
        if (m_pres >= 0) begin
            if (m_pres < 8 && m_nmi) m_pres = 8;
            else if (bus.int_ack) begin
                m_stack.push_back(m_pres);
                if (m_pres == 8) nclr = 1; else clr[m_pres] = 1'b1;
                m_pres = -1;
            end
        end else if (m_stack.size() == 0) begin
            if (m_nmi) m_pres = 8;
            else if (elig != 0) begin
                for (int k = 7; k >= 0; k--) if (elig[k]) m_pres = k;
            end
        end else if (bus.int_done) begin
            void'(m_stack.pop_back());
        end else if (m_stack[$] != 8 && m_nmi) begin
            m_pres = 8;
        end
        if (m_pres >= 0) m_cause = m_pres;
        else if (m_stack.size() != 0) m_cause = m_stack[$];
        m_pend = (m_pend & ~clr) | rise;
        m_nmi  = (m_nmi && !nclr) || nrise;
        m_prev_irq = IRQ;
        m_prev_nmi = NMI;
    endtask

    initial begin
        drive(1'b1, 1'b0, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);

        //                rst nmi irq    mask   gie ack done  req cause vec          pend
        tbl.push_back('{1, 0, 8'hFF, 8'hFF, 1, 0, 0,   0, 0, 32'h100, 8'h00}); // reset with lines high
        tbl.push_back('{0, 0, 8'h00, 8'hFF, 1, 0, 0,   0, 0, 32'h100, 8'h00});
        tbl.push_back('{0, 0, 8'h08, 8'hFF, 1, 0, 0,   0, 0, 32'h100, 8'h08}); // IRQ3 edge
        tbl.push_back('{0, 0, 8'h08, 8'hFF, 1, 0, 0,   1, 3, 32'h10C, 8'h08}); // request 2 edges later
        tbl.push_back('{0, 0, 8'h08, 8'hFF, 1, 1, 0,   0, 3, 32'h10C, 8'h00}); // ack clears pending
        tbl.push_back('{0, 0, 8'h00, 8'hFF, 1, 0, 1,   0, 3, 32'h10C, 8'h00}); // done
        tbl.push_back('{0, 0, 8'h24, 8'hFF, 1, 0, 0,   0, 3, 32'h10C, 8'h24}); // IRQ5+IRQ2
        tbl.push_back('{0, 0, 8'h24, 8'hFF, 1, 0, 0,   1, 2, 32'h108, 8'h24});
        tbl.push_back('{0, 0, 8'h24, 8'hFF, 1, 1, 0,   0, 2, 32'h108, 8'h20});
        tbl.push_back('{0, 0, 8'h24, 8'hFF, 1, 0, 1,   0, 2, 32'h108, 8'h20});
        tbl.push_back('{0, 0, 8'h24, 8'hFF, 1, 0, 0,   1, 5, 32'h114, 8'h20}); // then IRQ5
        tbl.push_back('{0, 0, 8'h24, 8'hFF, 1, 1, 0,   0, 5, 32'h114, 8'h00});
        tbl.push_back('{0, 0, 8'h00, 8'hFF, 1, 0, 1,   0, 5, 32'h114, 8'h00});
        tbl.push_back('{0, 0, 8'h02, 8'hFD, 1, 0, 0,   0, 5, 32'h114, 8'h02}); // IRQ1 masked
        tbl.push_back('{0, 0, 8'h02, 8'hFD, 1, 0, 0,   0, 5, 32'h114, 8'h02});
        tbl.push_back('{0, 0, 8'h02, 8'hFF, 1, 0, 0,   1, 1, 32'h104, 8'h02}); // unmask
        tbl.push_back('{0, 0, 8'h02, 8'hFF, 1, 1, 0,   0, 1, 32'h104, 8'h00});
        tbl.push_back('{0, 0, 8'h00, 8'hFF, 1, 0, 1,   0, 1, 32'h104, 8'h00});
        tbl.push_back('{0, 0, 8'h00, 8'hFF, 1, 1, 0,   0, 1, 32'h104, 8'h00}); // stray ack ignored
        tbl.push_back('{0, 0, 8'h01, 8'hFF, 0, 0, 0,   0, 1, 32'h104, 8'h01}); // glob_ie off
        tbl.push_back('{0, 0, 8'h01, 8'hFF, 0, 0, 0,   0, 1, 32'h104, 8'h01});
        tbl.push_back('{0, 0, 8'h01, 8'hFF, 1, 0, 0,   1, 0, 32'h100, 8'h01});
        tbl.push_back('{0, 0, 8'h01, 8'hFF, 1, 1, 0,   0, 0, 32'h100, 8'h00});
        tbl.push_back('{0, 0, 8'h00, 8'hFF, 1, 0, 1,   0, 0, 32'h100, 8'h00});

        foreach (tbl[r]) begin
            drive(tbl[r].rst, tbl[r].nmi, tbl[r].irq, tbl[r].mask, tbl[r].gie,
                  tbl[r].ack, tbl[r].done);
            @(posedge clk); #1;
            check_outs($sformatf("tbl%0d", r), tbl[r].req, tbl[r].cause, tbl[r].vec, tbl[r].pend);
        end

        // NMI preempts IRQ4 service even with glob_ie low, then returns to it.
        step("nmi1",  0, 8'h10, 1, 0, 0, 0, 4'd0, 8'h10);
        step("nmi2",  0, 8'h10, 1, 0, 0, 1, 4'd4, 8'h10);
        step("nmi3",  0, 8'h10, 1, 1, 0, 0, 4'd4, 8'h00);
        step("nmi4",  1, 8'h00, 0, 0, 0, 0, 4'd4, 8'h00);
        step("nmi5",  1, 8'h00, 0, 0, 0, 1, 4'd8, 8'h00);
        step("nmi6",  0, 8'h00, 0, 1, 0, 0, 4'd8, 8'h00);
        step("nmi7",  0, 8'h00, 0, 0, 1, 0, 4'd4, 8'h00);
        step("nmi8",  0, 8'h40, 1, 0, 0, 0, 4'd4, 8'h40); // still in IRQ4 service
        step("nmi9",  0, 8'h40, 1, 0, 0, 0, 4'd4, 8'h40);
        step("nmi10", 0, 8'h40, 1, 0, 1, 0, 4'd4, 8'h40);
        step("nmi11", 0, 8'h40, 1, 0, 0, 1, 4'd6, 8'h40);
        step("nmi12", 0, 8'h40, 1, 1, 0, 0, 4'd6, 8'h00);
        step("nmi13", 0, 8'h00, 1, 0, 1, 0, 4'd6, 8'h00);

        // IRQ0 re-rises on its own ack edge: the set wins.
        step("race1", 0, 8'h01, 1, 0, 0, 0, 4'd6, 8'h01);
        step("race2", 0, 8'h00, 1, 0, 0, 1, 4'd0, 8'h01);
        step("race3", 0, 8'h01, 1, 1, 0, 0, 4'd0, 8'h01);
        step("race4", 0, 8'h01, 1, 0, 1, 0, 4'd0, 8'h01);
        step("race5", 0, 8'h01, 1, 0, 0, 1, 4'd0, 8'h01);
        step("race6", 0, 8'h01, 1, 1, 0, 0, 4'd0, 8'h00);
        step("race7", 0, 8'h00, 1, 0, 1, 0, 4'd0, 8'h00);

        // NMI arriving in REQ abandons IRQ7 but keeps its pending bit.
        step("ab1", 0, 8'h80, 1, 0, 0, 0, 4'd0, 8'h80);
        step("ab2", 0, 8'h80, 1, 0, 0, 1, 4'd7, 8'h80);
        step("ab3", 1, 8'h80, 1, 0, 0, 1, 4'd7, 8'h80);
        step("ab4", 1, 8'h80, 1, 0, 0, 1, 4'd8, 8'h80);
        step("ab5", 0, 8'h80, 1, 1, 0, 0, 4'd8, 8'h80);
        step("ab6", 0, 8'h80, 1, 0, 1, 0, 4'd8, 8'h80);
        step("ab7", 0, 8'h80, 1, 0, 0, 1, 4'd7, 8'h80);
        step("ab8", 0, 8'h80, 1, 1, 0, 0, 4'd7, 8'h00);
        step("ab9", 0, 8'h00, 1, 0, 1, 0, 4'd7, 8'h00);

        // Randomized run against the reference model, with one mid-run reset.
        IRQ = 8'h00; NMI = 1'b0; irq_mask = 8'hFF; glob_ie = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            rst = (c == 0) || (c == 1200);
            IRQ = IRQ ^ 8'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 19) == 0) NMI = ~NMI;
            if ($urandom_range(0, 49) == 0) irq_mask = 8'($urandom | $urandom);
            glob_ie      = ($urandom_range(0, 99) < 85);
            bus.int_ack  = ($urandom_range(0, 2) == 0);
            bus.int_done = ($urandom_range(0, 3) == 0);
            @(posedge clk);
            model_step();
            #1;
            check_outs($sformatf("rnd%0d", c), m_pres >= 0, 4'(m_cause),
                       32'h100 + 32'(m_cause) * 4, m_pend);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
